// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the execute-stage multiply/divide unit.
// The ID decoder imports md_opc_e from here as well.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_opc_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_div(md_opc_e opc);
    return opc inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_rem(md_opc_e opc);
    return opc inside {MD_REM, MD_REMU};
  endfunction

  function automatic logic is_signed_a(md_opc_e opc);
    return opc inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic is_signed_b(md_opc_e opc);
    return opc inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-side handshake between the pipeline and the multiply/divide unit.
interface ex_muldiv_if #(parameter int XLEN = 32);
  logic            flush;
  logic            valid_in;
  logic [2:0]      opc;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      rd_in;
  logic            hold;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] res;
  logic [4:0]      rd;

  modport master (output flush, valid_in, opc, op1, op2, rd_in, hold,
                  input  busy, done, res, rd);
  modport slave  (input  flush, valid_in, opc, op1, op2, rd_in, hold,
                  output busy, done, res, rd);
endinterface

// File: rtl/md_step.sv
// One combinational iteration on the {hi,lo} working pair: restoring-divide
// step (quotient bits shift into lo) or shift-add multiply step (product shifts right).
module md_step #(parameter int XLEN = 32) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);
  logic [XLEN:0] sum;
  logic [XLEN:0] sh;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    sh   = {hi, lo[XLEN-1]};
    hi_n = sum[XLEN:1];
    lo_n = {sum[0], lo[XLEN-1:1]};
    if (is_div) begin
      // remainder < divisor, so sh < 2*divisor and the difference fits XLEN bits
      if (sh >= {1'b0, b}) begin
        hi_n = XLEN'(sh - {1'b0, b});
        lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = sh[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide beside the EX ALU: works on operand magnitudes,
// iterates XLEN steps (or finishes at issue for special cases), then sign-fixes.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input logic         clk,
  input logic         rst,
  ex_muldiv_if.slave  mif
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      tag_q, tag_d;
  md_opc_e         opc_q, opc_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic            neg_q, neg_d;

  md_opc_e           opc_in;
  logic              na, nb, div_zero, div_ovf, accept;
  logic [XLEN-1:0]   ma, mb, step_hi, step_lo, div_val;
  logic [2*XLEN-1:0] fast_prod;

  function automatic logic [XLEN-1:0] mul_fix(logic [2*XLEN-1:0] p, logic neg, md_opc_e o);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (o == MD_MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  md_step #(.XLEN(XLEN)) u_step (
    .is_div (is_div(opc_q)),
    .hi     (hi_q),
    .lo     (lo_q),
    .b      (b_q),
    .hi_n   (step_hi),
    .lo_n   (step_lo)
  );

  always_comb begin
    opc_in    = md_opc_e'(mif.opc);
    na        = is_signed_a(opc_in) & mif.op1[XLEN-1];
    nb        = is_signed_b(opc_in) & mif.op2[XLEN-1];
    ma        = na ? -mif.op1 : mif.op1;
    mb        = nb ? -mif.op2 : mif.op2;
    div_zero  = (mif.op2 == '0);
    div_ovf   = is_signed_b(opc_in) & (mif.op1 == MIN) & (mif.op2 == '1);
    fast_prod = {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb};
    accept    = (state_q == MD_IDLE) & mif.valid_in & ~mif.flush;
    div_val   = is_rem(opc_q) ? step_hi : step_lo;

    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    res_d   = res_q;
    rd_d    = rd_q;
    tag_d   = tag_q;
    opc_d   = opc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    neg_d   = neg_q;

    case (state_q)
      MD_IDLE: if (accept) begin
        opc_d = opc_in;
        tag_d = mif.rd_in;
        b_d   = mb;
        neg_d = is_rem(opc_in) ? na : (na ^ nb);
        if (is_div(opc_in) && (div_zero || div_ovf)) begin
          if (div_zero) res_d = is_rem(opc_in) ? mif.op1 : '1;
          else          res_d = is_rem(opc_in) ? '0 : MIN;
          rd_d    = mif.rd_in;
          done_d  = 1'b1;
          state_d = MD_DONE;
        end else if (FAST_MUL && !is_div(opc_in)) begin
          res_d   = mul_fix(fast_prod, na ^ nb, opc_in);
          rd_d    = mif.rd_in;
          done_d  = 1'b1;
          state_d = MD_DONE;
        end else begin
          hi_d    = '0;
          lo_d    = ma;
          count_d = CW'(XLEN-1);
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (count_q == '0) begin
          res_d   = is_div(opc_q) ? (neg_q ? -div_val : div_val)
                                  : mul_fix({step_hi, step_lo}, neg_q, opc_q);
          rd_d    = tag_q;
          done_d  = 1'b1;
          state_d = MD_DONE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      MD_DONE: if (!mif.hold) begin
        done_d  = 1'b0;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    // a flush must never publish a result, even on the final RUN step
    if (mif.flush) begin
      state_d = MD_IDLE;
      done_d  = 1'b0;
      res_d   = res_q;
      rd_d    = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      rd_q    <= '0;
      tag_q   <= '0;
      opc_q   <= MD_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      tag_q   <= tag_d;
      opc_q   <= opc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
    end
  end

  assign mif.busy = (state_q == MD_RUN) | accept | ((state_q == MD_DONE) & mif.hold);
  assign mif.done = done_q;
  assign mif.res  = res_q;
  assign mif.rd   = rd_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: iterative (dut0) and fast-multiply (dut1) instances.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] last_res0 = '0;

  ex_muldiv_if #(.XLEN(32)) if0();
  ex_muldiv_if #(.XLEN(32)) if1();

  ex_muldiv #(.XLEN(32), .FAST_MUL(1'b0)) dut0 (.clk(clk), .rst(rst), .mif(if0));
  ex_muldiv #(.XLEN(32), .FAST_MUL(1'b1)) dut1 (.clk(clk), .rst(rst), .mif(if1));

  logic        done_w [2];
  logic        busy_w [2];
  logic [31:0] res_w  [2];
  logic [4:0]  rd_w   [2];
  assign done_w[0] = if0.done;  assign done_w[1] = if1.done;
  assign busy_w[0] = if0.busy;  assign busy_w[1] = if1.busy;
  assign res_w[0]  = if0.res;   assign res_w[1]  = if1.res;
  assign rd_w[0]   = if0.rd;    assign rd_w[1]   = if1.rd;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: plain integer arithmetic on the architectural definitions.
  function automatic logic [31:0] ref_op(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = '0;
    case (o)
      3'd0, 3'd1: p = 64'(sa * sb);
      3'd2:       p = 64'(sa * ub);
      3'd3:       p = 64'(ua * ub);
      3'd4:       p = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(sa / sb);
      3'd5:       p = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(ua / ub);
      3'd6:       p = (b == 0) ? {32'h0, a} : 64'(sa % sb);
      default:    p = (b == 0) ? {32'h0, a} : 64'(ua % ub);
    endcase
    return (o == 3'd1 || o == 3'd2 || o == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  function automatic int lat(int d, logic [2:0] o, logic [31:0] a, logic [31:0] b);
    if (o >= 3'd4 && (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    if (d == 1 && o < 3'd4) return 1;
    return 33;
  endfunction

  task automatic drive(int d, logic v, logic [2:0] o, logic [31:0] a, logic [31:0] b,
                       logic [4:0] r, logic h, logic f);
    if (d == 0) begin
      if0.valid_in = v; if0.opc = o; if0.op1 = a; if0.op2 = b;
      if0.rd_in = r; if0.hold = h; if0.flush = f;
    end else begin
      if1.valid_in = v; if1.opc = o; if1.op1 = a; if1.op2 = b;
      if1.rd_in = r; if1.hold = h; if1.flush = f;
    end
  endtask

  // Issue one op, push its expectation, then wait (checking busy) until it retires.
  task automatic run_op(int d, logic [2:0] o, logic [31:0] a, logic [31:0] b,
                        logic [4:0] r, logic [31:0] e_res, int hold_pct, bit junk);
    exp_t e;
    int   n;
    logic h;
    @(negedge clk);
    drive(d, 1'b1, o, a, b, r, 1'($urandom_range(1)), 1'b0);
    e.res = e_res; e.rd = r; e.due = cyc + lat(d, o, a, b);
    if (d == 0) begin q0.push_back(e); last_res0 = e_res; end
    else q1.push_back(e);
    #1 chk("busy_issue", 64'(busy_w[d]), 64'(1));
    n = 0;
    forever begin
      @(negedge clk);
      h = ($urandom_range(99) < hold_pct);
      drive(d, junk ? 1'($urandom_range(1)) : 1'b0, 3'($urandom), $urandom, $urandom,
            5'($urandom), h, 1'b0);
      #1 chk("busy_wait", 64'(busy_w[d]), done_w[d] ? 64'(h) : 64'(1));
      if (done_w[d] && !h) break;
      if (++n > 300) begin fail_now("run_op_timeout"); break; end
    end
    drive(d, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic idle_check(string nm, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk({nm, "_done"}, 64'(done_w[0]), 64'(0));
      chk({nm, "_busy"}, 64'(busy_w[0]), 64'(0));
    end
  endtask

  task automatic monitor(int d);
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_w[d] && !prev) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) fail_now($sformatf("dut%0d_unexpected_done", d));
        else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("dut%0d_res", d), 64'(res_w[d]), 64'(e.res));
          chk($sformatf("dut%0d_rd", d), 64'(rd_w[d]), 64'(e.rd));
          chk($sformatf("dut%0d_done_cycle", d), 64'(cyc), 64'(e.due));
        end
      end
      prev = done_w[d];
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(300, 1));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] o;
    logic [31:0] a, b;
    int n;
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    drive(1, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_done", 64'(done_w[d]), 64'(0));
      chk("reset_busy", 64'(busy_w[d]), 64'(0));
      chk("reset_res",  64'(res_w[d]),  64'(0));
      chk("reset_rd",   64'(rd_w[d]),   64'(0));
    end

    // Directed cases with hand-derived results
    run_op(0, 3'd5, 32'd100, 32'd7, 5'd5, 32'd14, 0, 0);
    run_op(0, 3'd7, 32'd100, 32'd7, 5'd6, 32'd2, 0, 0);
    run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 0, 0);
    run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 0, 0);
    run_op(0, 3'd1, 32'hFFFF_FFFD, 32'd5, 5'd9, 32'hFFFF_FFFF, 0, 0);
    run_op(0, 3'd0, 32'hFFFF_FFFD, 32'd5, 5'd10, 32'hFFFF_FFF1, 0, 0);
    run_op(0, 3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 0, 0);
    run_op(0, 3'd7, 32'd5, 32'd0, 5'd12, 32'd5, 0, 0);
    run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0, 0);
    run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, 0, 0);
    run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, 0, 0);
    run_op(0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'h1, 0, 0);
    run_op(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFE, 0, 0);
    run_op(1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'h1, 0, 0);
    run_op(1, 3'd1, 32'hFFFF_FFFD, 32'd5, 5'd9, 32'hFFFF_FFFF, 0, 0);
    run_op(1, 3'd5, 32'd100, 32'd7, 5'd5, 32'd14, 0, 0);

    // Held result stays stable, then releases into an immediate new issue
    @(negedge clk);
    drive(0, 1'b1, 3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 1'b0);
    q0.push_back('{res: 32'd14, rd: 5'd9, due: cyc + 33});
    last_res0 = 32'd14;
    n = 0;
    do begin
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
      #1 n++;
    end while (!done_w[0] && n < 100);
    if (!done_w[0]) fail_now("hold_timeout");
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk("hold_done", 64'(done_w[0]), 64'(1));
      chk("hold_res",  64'(res_w[0]),  64'(14));
      chk("hold_rd",   64'(rd_w[0]),   64'(9));
      chk("hold_busy", 64'(busy_w[0]), 64'(1));
    end
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1 chk("release_busy", 64'(busy_w[0]), 64'(0));
    run_op(0, 3'd7, 32'd23, 32'd4, 5'd3, 32'd3, 0, 0);

    // flush beats valid_in in IDLE
    @(negedge clk);
    drive(0, 1'b1, 3'd5, 32'd100, 32'd7, 5'd3, 1'b0, 1'b1);
    #1 chk("flush_prio_busy", 64'(busy_w[0]), 64'(0));
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    idle_check("flush_prio", 36);

    // flush at cycle 10 of a DIVU
    @(negedge clk);
    drive(0, 1'b1, 3'd5, 32'd1000, 32'd3, 5'd21, 1'b0, 1'b0);
    repeat (10) begin
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    end
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    #1 chk("flush_res_kept", 64'(res_w[0]), 64'(last_res0));
    idle_check("flush_run", 40);

    // reset at cycle 10 of a DIVU
    @(negedge clk);
    drive(0, 1'b1, 3'd5, 32'd1000, 32'd3, 5'd22, 1'b0, 1'b0);
    repeat (10) begin
      @(negedge clk);
      drive(0, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_res", 64'(res_w[0]), 64'(0));
    chk("rst_rd",  64'(rd_w[0]),  64'(0));
    last_res0 = '0;
    idle_check("rst_run", 40);

    // Randomized ops on both instances with random hold and ignored junk issues
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 50; k++) begin
        o = 3'($urandom);
        a = rnd_val();
        b = rnd_val();
        run_op(d, o, a, b, 5'($urandom), ref_op(o, a, b), 30, 1'b1);
        repeat ($urandom_range(2)) @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'(0));
    chk("q1_drained", 64'(q1.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
